// File: rtl/weight_loader_pkg.sv
// Shared definitions for the convolution blocks: default kernel geometry and
// the weight loader FSM state encoding.
package weight_loader_pkg;

  localparam int WL_NUM_W   = 25;
  localparam int WL_W_WIDTH = 8;
  localparam int WL_ADDR_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } wl_state_e;

endpackage : weight_loader_pkg

// File: rtl/weight_loader.sv
// Streams NUM_W incoming weights into weight storage at addresses 0..NUM_W-1,
// with bubble tolerance, abort, and a one-cycle completion pulse.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int NUM_W   = WL_NUM_W,
  parameter int W_WIDTH = WL_W_WIDTH,
  parameter int ADDR_W  = WL_ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [W_WIDTH-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [W_WIDTH-1:0] o_w,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_wr_en,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_W - 1);

  wl_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [W_WIDTH-1:0] w_q,     w_d;
  logic               wr_en_q, wr_en_d;

  // Reset gates ready so nothing is offered upstream while reset is held.
  assign o_ready = (state_q == ST_LOAD) && !i_abort && !i_rst;

  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    w_d     = w_q;
    wr_en_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (i_valid) begin
          wr_en_d = 1'b1;
          w_d     = i_data;
          addr_d  = cnt_q;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      w_q     <= '0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      wr_en_q <= wr_en_d;
    end
  end

  assign o_w     = w_q;
  assign o_addr  = addr_q;
  assign o_wr_en = wr_en_q;
  assign o_busy  = (state_q != ST_IDLE);
  assign o_done  = (state_q == ST_DONE);

endmodule : weight_loader
